// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM state type and op decode helpers for muldiv_unit
//
// Purpose: shared constants for the iterative multiply/divide unit.
//   OP_*     : RV32M funct3 encodings carried on muldiv_unit.op
//   state_t  : FSM state type, S_* the state constants
//   op_*()   : small decode helpers used by the unit
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_PREP = 3'd1;
  localparam state_t S_CALC = 3'd2;
  localparam state_t S_FIX  = 3'd3;
  localparam state_t S_DONE = 3'd4;

  // All divide/remainder ops have funct3[2] set.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // MULHSU treats B as unsigned.
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - combinational single radix-2 iteration for multiply or divide
//
// Purpose: one step of shift-add multiply or restoring shift-subtract divide.
// Ports:
//   is_div  : 1 selects the divide step, 0 the multiply step
//   acc_in  : 2*WIDTH working register; multiply {partial_hi, multiplier},
//             divide {remainder, dividend/quotient}
//   operand : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_out : working register after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set; the carry becomes the new top bit after shifting.
    sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);

    // Divide: bring the next dividend bit into the remainder. The shifted
    // value can need WIDTH+1 bits, so the trial subtract carries an extra
    // bit to keep the borrow distinct from the magnitude.
    shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, operand};

    if (is_div) begin
      if (trial[WIDTH+1]) begin
        acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M-style multiply/divide unit with valid/ready handshake
//
// Purpose: sequential multiply/divide, WIDTH+2 cycles from acceptance to result.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake (ready only while idle)
//   op, a_in, b_in        : funct3 op and operands, latched on acceptance
//   out_valid / out_ready : result handshake
//   result                : operation result
//   div_by_zero, overflow : flags, meaningful while out_valid
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 dbz_q, dbz_d;
  logic                 ovf_q, ovf_d;

  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;
  logic                 div_zero, div_ovf;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_is_div(op_q)),
    .acc_in  (acc_q),
    .operand (opnd_q),
    .acc_out (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;

    mag_a = (op_a_signed(op_q) && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b = (op_b_signed(op_q) && b_q[WIDTH-1]) ? -b_q : b_q;

    // Sign correction applied to the unsigned core results.
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    div_zero = op_is_div(op_q) && (b_q == '0);
    div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
               (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = a_in;
          b_d     = b_in;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sa_d = op_a_signed(op_q) && a_q[WIDTH-1];
        sb_d = op_b_signed(op_q) && b_q[WIDTH-1];
        // Divide shifts the dividend out of the low half; multiply shifts
        // the multiplier out of the low half.
        if (op_is_div(op_q)) begin
          acc_d  = {{WIDTH{1'b0}}, mag_a};
          opnd_d = mag_b;
        end else begin
          acc_d  = {{WIDTH{1'b0}}, mag_b};
          opnd_d = mag_a;
        end
        cnt_d   = CNT_W'(WIDTH - 1);
        state_d = S_CALC;
      end
      S_CALC: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        case (op_q)
          OP_MUL:                       result_d = prod[WIDTH-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*WIDTH-1:WIDTH];
          OP_DIV, OP_DIVU:              result_d = div_zero ? '1 : (div_ovf ? a_q : quo);
          OP_REM, OP_REMU:              result_d = div_zero ? a_q : (div_ovf ? '0 : rem);
          default:                      result_d = '0;
        endcase
        dbz_d   = div_zero;
        ovf_d   = div_ovf;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit (WIDTH=32)
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;
  logic        overflow;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
    longint      t;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  bit     prev_valid = 0;
  longint hs_time = 0;
  longint last_accept = 0;
  int     seen_valid = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic edz, input logic eov);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    a_in     = a;
    b_in     = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.res = er;
    e.dbz = edz;
    e.ovf = eov;
    e.t   = longint'($time);
    sb.push_back(e);
    last_accept = longint'($time);
    #1;
    // Scramble the request fields: the unit must have latched them already.
    in_valid = 1'b0;
    op       = 3'($urandom);
    a_in     = $urandom;
    b_in     = $urandom;
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_valid = 0;
    end else begin
      if (out_valid) begin
        seen_valid++;
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result at %0t", $time);
        end else begin
          e = sb[0];
          if (!prev_valid)
            chk("latency", 64'((longint'($time) - 5 - e.t) / 10), 64'd34);
          if (out_ready) begin
            chk("result", 64'(result), 64'(e.res));
            chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            chk("overflow", 64'(overflow), 64'(e.ovf));
            void'(sb.pop_front());
            hs_time = longint'($time) + 5;
          end else begin
            chk("hold_result", 64'(result), 64'(e.res));
            chk("hold_flags", 64'({div_by_zero, overflow}), 64'({e.dbz, e.ovf}));
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 3'd0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);

    // Multiply group
    send(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0);
    send(3'b000, 32'h12345678, 32'h10,       32'h23456780, 1'b0, 1'b0);
    send(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
    send(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
    send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    send(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);

    // Divide group
    send(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0);
    send(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
    send(3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 1'b0, 1'b0);
    send(3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
    send(3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0);

    // Special cases
    send(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
    send(3'b111, 32'd5,        32'd0,        32'd5,        1'b1, 1'b0);
    send(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
    send(3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1, 1'b0);
    send(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);
    send(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b1);

    // Back-to-back: second request waits for the first handshake plus one idle cycle.
    send(3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
    send(3'b101, 32'd9, 32'd3, 32'd3,  1'b0, 1'b0);
    chk("b2b_accept_gap", 64'(last_accept - hs_time), 64'd10);

    // Stall in DONE for 5 cycles.
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    send(3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached_done", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid_held", 64'(out_valid), 64'd1);
      chk("stall_result", 64'(result), 64'h00000001);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;

    // Abort mid-CALC; a request presented during reset must not be taken.
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    send(3'b101, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    op       = 3'b000;
    a_in     = 32'd1;
    b_in     = 32'd1;
    sb.delete();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    seen_valid = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_valid", 64'(seen_valid), 64'd0);

    // Unit still operational after the abort.
    send(3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
